// File: rtl/remap_cache_fill_ctrl.sv
// remap_cache_fill_ctrl: per-slot fill/lifetime control, cache write beats and read gating
`timescale 1ns/1ps
module remap_cache_fill_ctrl #(
    parameter int N_ICFG  = 4,
    parameter int HBW     = 8,
    parameter int VSIZE   = 32,
    parameter int DBW     = 16,
    parameter int ICFG_BW = $clog2(N_ICFG + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 alloc_rdy,
    output logic                 alloc_ack,
    input  logic [ICFG_BW-1:0]   i_alloc_id,
    input  logic [HBW-1:0]       i_alloc_base,
    input  logic [HBW:0]         i_alloc_len,
    input  logic                 fill_rdy,
    output logic                 fill_ack,
    input  logic [VSIZE*DBW-1:0] i_fill_data,
    output logic                 wad_dval,
    output logic [ICFG_BW-1:0]   o_wid,
    output logic [HBW-1:0]       o_whiaddr,
    output logic [VSIZE*DBW-1:0] o_wdata,
    input  logic                 up_ra_rdy,
    output logic                 up_ra_ack,
    input  logic [ICFG_BW-1:0]   i_rid,
    output logic                 ra_rdy,
    input  logic                 ra_ack,
    input  logic                 free_dval,
    input  logic                 i_false_alloc,
    input  logic [ICFG_BW-1:0]   i_free_id,
    output logic [N_ICFG-1:0]    o_slot_ready,
    output logic                 o_err
);
    localparam int NX = 1 << ICFG_BW;
    typedef enum logic [1:0] {EMPTY, FILLING, READY} slot_t;
    typedef enum logic {IDLE, FILL} state_t;
    slot_t slot [N_ICFG];
    state_t state, state_n;
    logic [N_ICFG-1:0] is_empty, is_ready;
    logic [NX-1:0] empty_x, ready_x;
    logic [ICFG_BW-1:0] id_q;
    logic [HBW-1:0] base_q;
    logic [HBW:0] len_q, cnt;
    logic last_q, fill_last, free_ok;
    always_comb begin
        for (int i = 0; i < N_ICFG; i++) begin
            is_empty[i] = slot[i] == EMPTY;
            is_ready[i] = slot[i] == READY;
        end
    end
    assign empty_x = NX'(is_empty);
    assign ready_x = NX'(is_ready);
    assign o_slot_ready = is_ready;
    assign fill_last = (cnt + (HBW+1)'(1)) == len_q;
    assign free_ok = free_dval & ~i_false_alloc;
    assign ra_rdy = up_ra_rdy & ready_x[i_rid];
    assign up_ra_ack = ra_ack;
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        alloc_ack = 1'b0;
        fill_ack = 1'b0;
        if (state == IDLE) begin
            alloc_ack = alloc_rdy & empty_x[i_alloc_id];
            state_n = (alloc_ack && i_alloc_len != '0) ? FILL : IDLE;
        end else begin
            fill_ack = fill_rdy;
            state_n = (fill_ack && fill_last) ? IDLE : FILL;
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wad_dval <= 1'b0;
            last_q <= 1'b0;
            o_wid <= '0;
            o_whiaddr <= '0;
            o_wdata <= '0;
            o_err <= 1'b0;
            id_q <= '0;
            base_q <= '0;
            len_q <= '0;
            cnt <= '0;
            for (int i = 0; i < N_ICFG; i++) slot[i] <= EMPTY;
        end else begin
            wad_dval <= fill_ack;
            last_q <= fill_ack & fill_last;
            o_err <= o_err | (free_ok & ~ready_x[i_free_id]);
            if (alloc_ack) begin
                id_q <= i_alloc_id;
                base_q <= i_alloc_base;
                len_q <= i_alloc_len;
                cnt <= '0;
            end
            if (fill_ack) begin
                cnt <= cnt + (HBW+1)'(1);
                o_wid <= id_q;
                o_whiaddr <= base_q + cnt[HBW-1:0];
                o_wdata <= i_fill_data;
            end
            for (int i = 0; i < N_ICFG; i++) begin
                if (last_q && id_q == ICFG_BW'(i))
                    slot[i] <= READY;
                else if (alloc_ack && i_alloc_id == ICFG_BW'(i))
                    slot[i] <= (i_alloc_len == '0) ? READY : FILLING;
                else if (free_ok && i_free_id == ICFG_BW'(i) && slot[i] == READY)
                    slot[i] <= EMPTY;
            end
        end
    end
endmodule

// File: tb/tb_remap_cache_fill_ctrl.sv
// tb_remap_cache_fill_ctrl: directed and random checks of the fill controller against a slot-lifetime model
`timescale 1ns/1ps
module tb_remap_cache_fill_ctrl;
    localparam int W = 512;
    localparam int EMPTY = 0, FILLING = 1, READY = 2;
    logic i_clk = 1'b0, i_rst;
    logic alloc_rdy, alloc_ack, fill_rdy, fill_ack, wad_dval;
    logic [2:0] i_alloc_id, o_wid, i_rid, i_free_id;
    logic [7:0] i_alloc_base, o_whiaddr;
    logic [8:0] i_alloc_len;
    logic [W-1:0] i_fill_data, o_wdata;
    logic up_ra_rdy, up_ra_ack, ra_rdy, ra_ack, free_dval, i_false_alloc, o_err;
    logic [3:0] o_slot_ready;
    int checks = 0, failures = 0;
    int m_slot [4];
    longint ready_at [4];
    bit m_act, mvalid = 1'b0;
    int m_fid, m_addr, m_rem, exp_wid, exp_addr;
    bit exp_wad, exp_err;
    logic [W-1:0] exp_wdata;
    longint ecyc;
    int ncyc = 0, xfers = 0, xfer_cyc = -1, ack_p = 100;
    bit one_shot = 1'b1;
    int rise_cyc [4];
    logic [3:0] prev_rdy = '0;
    int wl_addr[$], wl_id[$], wl_cyc[$];
    logic [W-1:0] wl_data[$];
    int ea [4];
    int s;

    remap_cache_fill_ctrl dut (
        .i_clk(i_clk), .i_rst(i_rst), .alloc_rdy(alloc_rdy), .alloc_ack(alloc_ack),
        .i_alloc_id(i_alloc_id), .i_alloc_base(i_alloc_base), .i_alloc_len(i_alloc_len),
        .fill_rdy(fill_rdy), .fill_ack(fill_ack), .i_fill_data(i_fill_data),
        .wad_dval(wad_dval), .o_wid(o_wid), .o_whiaddr(o_whiaddr), .o_wdata(o_wdata),
        .up_ra_rdy(up_ra_rdy), .up_ra_ack(up_ra_ack), .i_rid(i_rid), .ra_rdy(ra_rdy),
        .ra_ack(ra_ack), .free_dval(free_dval), .i_false_alloc(i_false_alloc),
        .i_free_id(i_free_id), .o_slot_ready(o_slot_ready), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string n, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", n, got, exp);
        end
    endtask

    always @(posedge i_clk) begin : model
        int old [4];
        bit a, f;
        if (i_rst) begin
            mvalid = 1'b1;
            m_act = 1'b0;
            exp_wad = 1'b0;
            exp_err = 1'b0;
            ecyc = 0;
            for (int i = 0; i < 4; i++) begin
                m_slot[i] = EMPTY;
                ready_at[i] = -1;
            end
        end else if (mvalid) begin
            old = m_slot;
            a = !m_act && alloc_rdy && i_alloc_id < 4 && old[i_alloc_id] == EMPTY;
            f = m_act && fill_rdy;
            ecyc++;
            for (int i = 0; i < 4; i++)
                if (ready_at[i] == ecyc) begin
                    m_slot[i] = READY;
                    ready_at[i] = -1;
                end
            exp_wad = f;
            if (f) begin
                exp_wid = m_fid;
                exp_addr = m_addr;
                exp_wdata = i_fill_data;
                m_addr = (m_addr + 1) % 256;
                m_rem--;
                if (m_rem == 0) begin
                    m_act = 1'b0;
                    ready_at[m_fid] = ecyc + 1;
                end
            end
            if (a) begin
                if (i_alloc_len == 0) m_slot[i_alloc_id] = READY;
                else begin
                    m_slot[i_alloc_id] = FILLING;
                    m_act = 1'b1;
                    m_fid = i_alloc_id;
                    m_addr = i_alloc_base;
                    m_rem = i_alloc_len;
                end
            end
            if (free_dval && !i_false_alloc) begin
                if (i_free_id < 4 && old[i_free_id] == READY) m_slot[i_free_id] = EMPTY;
                else exp_err = 1'b1;
            end
        end
    end

    always @(negedge i_clk) begin : compare
        logic [3:0] er;
        ncyc++;
        if (wad_dval) begin
            wl_addr.push_back(o_whiaddr);
            wl_id.push_back(o_wid);
            wl_cyc.push_back(ncyc);
            wl_data.push_back(o_wdata);
        end
        for (int i = 0; i < 4; i++) if (o_slot_ready[i] && !prev_rdy[i]) rise_cyc[i] = ncyc;
        prev_rdy = o_slot_ready;
        if (mvalid) begin
            for (int i = 0; i < 4; i++) er[i] = m_slot[i] == READY;
            chk("alloc_ack", alloc_ack, !m_act && alloc_rdy && i_alloc_id < 4 && m_slot[i_alloc_id] == EMPTY);
            chk("fill_ack", fill_ack, m_act && fill_rdy);
            chk("ra_rdy", ra_rdy, up_ra_rdy && i_rid < 4 && m_slot[i_rid] == READY);
            chk("up_ra_ack", up_ra_ack, ra_ack);
            chk("wad_dval", wad_dval, exp_wad);
            chk("o_err", o_err, exp_err);
            chk("slot_ready", o_slot_ready, er);
            if (exp_wad) begin
                chk("o_wid", o_wid, exp_wid);
                chk("o_whiaddr", o_whiaddr, exp_addr);
                chk("o_wdata", o_wdata, exp_wdata);
            end
        end
    end

    task automatic tick();
        bit xf;
        #1;
        ra_ack = ra_rdy && ($urandom_range(99) < ack_p);
        xf = ra_rdy && ra_ack;
        if (xf) begin
            xfers++;
            xfer_cyc = ncyc + 1;
        end
        @(posedge i_clk);
        #1;
        ra_ack = 1'b0;
        if (xf && one_shot) up_ra_rdy = 1'b0;
    endtask

    task automatic alloc(input int id, input int base, input int len);
        alloc_rdy = 1'b1;
        i_alloc_id = 3'(id);
        i_alloc_base = 8'(base);
        i_alloc_len = 9'(len);
    endtask

    task automatic row(input int k);
        fill_rdy = 1'b1;
        i_fill_data = {16{32'(32'hD000_0000 + k)}};
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        i_rst = 1'b1; alloc_rdy = 0; i_alloc_id = 0; i_alloc_base = 0; i_alloc_len = 0;
        fill_rdy = 0; i_fill_data = '0; up_ra_rdy = 0; i_rid = 0; ra_ack = 0;
        free_dval = 0; i_false_alloc = 0; i_free_id = 0;
        repeat (2) tick();
        chk("rst_wad", wad_dval, 0);
        chk("rst_wid", o_wid, 0);
        chk("rst_addr", o_whiaddr, 0);
        chk("rst_wdata", o_wdata, 0);
        chk("rst_ready", o_slot_ready, 0);
        chk("rst_err", o_err, 0);
        i_rst = 1'b0;
        up_ra_rdy = 1'b1; i_rid = 1;
        alloc(1, 'h10, 3);
        #1 chk("t1_alloc_ack", alloc_ack, 1);
        tick();
        alloc_rdy = 1'b0;
        s = wl_addr.size();
        for (int k = 0; k < 3; k++) row(k);
        fill_rdy = 1'b0;
        for (int w = 0; w < 20 && xfers == 0; w++) tick();
        ea = '{'h10, 'h11, 'h12, 0};
        chk("t1_nwrites", wl_addr.size() - s, 3);
        for (int k = 0; k < 3; k++) begin
            chk("t1_addr", wl_addr[s+k], ea[k]);
            chk("t1_id", wl_id[s+k], 1);
        end
        chk("t1_data2", wl_data[s+2], {16{32'hD000_0002}});
        chk("t1_consec", wl_cyc[s+2] - wl_cyc[s], 2);
        chk("t1_ready_rise", rise_cyc[1], wl_cyc[s+2] + 1);
        chk("t1_xfers", xfers, 1);
        chk("t1_xfer_cyc", xfer_cyc, rise_cyc[1]);
        tick();
        chk("t1_one_xfer", xfers, 1);
        free_dval = 1'b1; i_free_id = 1; i_false_alloc = 1'b1;
        tick();
        chk("false_free_keeps", o_slot_ready[1], 1);
        i_false_alloc = 1'b0;
        tick();
        chk("free_empties", o_slot_ready[1], 0);
        chk("free_no_err", o_err, 0);
        i_free_id = 3;
        tick();
        free_dval = 1'b0;
        chk("free_empty_err", o_err, 1);
        tick();
        chk("err_sticky", o_err, 1);
        alloc(2, 'hFE, 4);
        tick();
        alloc_rdy = 1'b0;
        s = wl_addr.size();
        row(0); row(1);
        fill_rdy = 1'b0;
        tick();
        row(2); row(3);
        fill_rdy = 1'b0;
        repeat (2) tick();
        ea = '{'hFE, 'hFF, 'h00, 'h01};
        chk("wrap_nwrites", wl_addr.size() - s, 4);
        for (int k = 0; k < 4; k++) chk("wrap_addr", wl_addr[s+k], ea[k]);
        chk("wrap_ready", o_slot_ready[2], 1);
        alloc(2, 0, 1);
        #1 chk("held_alloc0", alloc_ack, 0);
        repeat (2) tick();
        free_dval = 1'b1; i_free_id = 2;
        #1 chk("held_alloc_free_cycle", alloc_ack, 0);
        tick();
        free_dval = 1'b0;
        #1 chk("held_alloc_next", alloc_ack, 1);
        tick();
        alloc_rdy = 1'b0;
        row(9);
        fill_rdy = 1'b0;
        repeat (2) tick();
        alloc(0, 'h40, 5);
        tick();
        alloc_rdy = 1'b0;
        s = wl_addr.size();
        row(0); row(1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        repeat (4) tick();
        fill_rdy = 1'b0;
        chk("rst_mid_writes", wl_addr.size() - s, 2);
        chk("rst_mid_ready", o_slot_ready, 0);
        chk("rst_mid_err", o_err, 0);
        s = wl_addr.size();
        alloc(3, 0, 0);
        #1 chk("len0_ack", alloc_ack, 1);
        tick();
        alloc_rdy = 1'b0;
        chk("len0_ready", o_slot_ready[3], 1);
        tick();
        chk("len0_nowrite", wl_addr.size() - s, 0);
        ack_p = 60;
        one_shot = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            i_rst = $urandom_range(499) == 0;
            alloc_rdy = $urandom_range(3) == 0;
            i_alloc_id = 3'($urandom_range(3));
            i_alloc_base = 8'($urandom);
            i_alloc_len = 9'(($urandom_range(7) == 0) ? $urandom_range(256) : $urandom_range(5));
            fill_rdy = $urandom_range(9) < 7;
            for (int k = 0; k < 16; k++) i_fill_data[k*32 +: 32] = $urandom;
            up_ra_rdy = 1'($urandom_range(1));
            i_rid = 3'($urandom_range(3));
            free_dval = $urandom_range(5) == 0;
            i_false_alloc = $urandom_range(3) == 0;
            i_free_id = 3'($urandom_range(3));
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
